ctrl_pipeline: RTL

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline_if.sv | 29 ++
 rtl/ctrl_pipeline.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline_if.sv
// Purpose : bundles the decode-side handshake and per-stage control outputs of ctrl_pipeline.
// Latency : none (signal bundle only).
// Backpr. : decode_ready low means the presented instruction is held upstream.
// Ports   : master = instruction source / observer (drives in_valid, instr, stall, flush);
//           slave  = ctrl_pipeline (drives decode_ready, hazard, illegal_op, stage_*, bubble_count).
interface ctrl_pipeline_if #(
  parameter int NUM_STAGES = 3
);
  logic                       in_valid;
  logic [15:0]                instr;
  logic                       stall;
  logic                       flush;
  logic                       decode_ready;
  logic                       hazard;
  logic                       illegal_op;
  logic [NUM_STAGES-1:0]      stage_valid;
  logic [NUM_STAGES*22-1:0]   stage_ctrl;
  logic [15:0]                bubble_count;

  modport master (
    output in_valid, instr, stall, flush,
    input  decode_ready, hazard, illegal_op, stage_valid, stage_ctrl, bubble_count
  );

  modport slave (
    input  in_valid, instr, stall, flush,
    output decode_ready, hazard, illegal_op, stage_valid, stage_ctrl, bubble_count
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// Purpose : LC-3b decode plus NUM_STAGES-deep control-word pipeline with load-use
//           hazard bubbling, stall hold, partial flush and a saturating bubble counter.
// Latency : accepted instruction reaches stage i after i+1 unstalled edges; decode is combinational.
// Backpr. : decode_ready = ~stall & ~hazard (forced 1 on flush, where the instruction is dropped).
// Ports   : clk, rst (async active-high), bus (ctrl_pipeline_if.slave).
//           Control word: [3:0] opcode [6:4] aluop [7] load_cc [8] is_br [9] is_j
//           [10] load_regfile [12:11] regfilemux_sel [14:13] alumux_sel [15] mem_read
//           [16] mem_write [17] sr2mux_sel [18] offset_sel [21:19] dest.
module ctrl_pipeline #(
  parameter int NUM_STAGES  = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_pipeline_if.slave bus
);

  typedef struct packed {
    logic [2:0] dest;
    logic       offset_sel;
    logic       sr2mux_sel;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] alumux_sel;
    logic [1:0] regfilemux_sel;
    logic       load_regfile;
    logic       is_j;
    logic       is_br;
    logic       load_cc;
    logic [2:0] aluop;
    logic [3:0] opcode;
  } ctrl_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;

  // Decode
  ctrl_t      dec;
  logic       dec_illegal;
  logic       use_src1;
  logic       use_src2;
  logic [2:0] src1;
  logic [2:0] src2;
  logic [3:0] op;

  assign op = bus.instr[15:12];

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    use_src1    = 1'b0;
    use_src2    = 1'b0;
    src1        = bus.instr[8:6];
    src2        = bus.instr[2:0];
    case (op)
      OP_ADD, OP_AND: begin
        dec.opcode       = op;
        dec.aluop        = (op == OP_ADD) ? ALU_ADD : ALU_AND;
        dec.load_cc      = 1'b1;
        dec.load_regfile = 1'b1;
        dec.sr2mux_sel   = bus.instr[5];
        dec.dest         = bus.instr[11:9];
        use_src1         = 1'b1;
        // immediate form has no second register source
        use_src2         = ~bus.instr[5];
      end
      OP_NOT: begin
        dec.opcode       = op;
        dec.aluop        = ALU_NOT;
        dec.load_cc      = 1'b1;
        dec.load_regfile = 1'b1;
        dec.dest         = bus.instr[11:9];
        use_src1         = 1'b1;
      end
      OP_LDR: begin
        dec.opcode         = op;
        dec.aluop          = ALU_ADD;
        dec.load_cc        = 1'b1;
        dec.alumux_sel     = 2'b01;
        dec.load_regfile   = 1'b1;
        dec.regfilemux_sel = 2'b01;
        dec.mem_read       = 1'b1;
        dec.dest           = bus.instr[11:9];
        use_src1           = 1'b1;
      end
      OP_STR: begin
        dec.opcode     = op;
        dec.aluop      = ALU_ADD;
        dec.alumux_sel = 2'b01;
        dec.mem_write  = 1'b1;
        use_src1       = 1'b1;
        // store data register lives in the dest field
        use_src2       = 1'b1;
        src2           = bus.instr[11:9];
      end
      OP_BR: begin
        dec.opcode = op;
        dec.is_br  = 1'b1;
      end
      OP_JMP: begin
        dec.opcode = op;
        dec.is_j   = 1'b1;
        use_src1   = 1'b1;
      end
      OP_LEA: begin
        dec.opcode         = op;
        dec.load_regfile   = 1'b1;
        dec.regfilemux_sel = 2'b10;
        dec.offset_sel     = 1'b1;
        dec.dest           = bus.instr[11:9];
      end
      default: begin
        // unknown opcode travels as an all-zero NOP word
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Pipeline state
  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_nxt;
  ctrl_t                 ctrl_q   [NUM_STAGES];
  ctrl_t                 ctrl_nxt [NUM_STAGES];
  logic [15:0]           bubble_cnt;
  logic [15:0]           bubble_cnt_nxt;

  logic hazard;
  logic take;
  logic src_hit;

  assign src_hit = (use_src1 && (ctrl_q[0].dest == src1)) ||
                   (use_src2 && (ctrl_q[0].dest == src2));

  // a redirect kills the dependent instruction anyway, so no bubble is needed
  assign hazard = bus.in_valid && vld_q[0] && ctrl_q[0].mem_read && src_hit && !bus.flush;
  assign take   = bus.in_valid && !hazard;

  always_comb begin
    vld_nxt  = vld_q;
    ctrl_nxt = ctrl_q;
    if (bus.flush) begin
      // flush wins over stall: youngest stages squashed, older ones still drain
      vld_nxt[0]  = 1'b0;
      ctrl_nxt[0] = '0;
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (i < FLUSH_DEPTH) begin
          vld_nxt[i]  = 1'b0;
          ctrl_nxt[i] = '0;
        end else begin
          vld_nxt[i]  = vld_q[i-1];
          ctrl_nxt[i] = ctrl_q[i-1];
        end
      end
    end else if (!bus.stall) begin
      vld_nxt[0]  = take;
      // bubbles always carry a zero word
      ctrl_nxt[0] = take ? dec : '0;
      for (int i = 1; i < NUM_STAGES; i++) begin
        vld_nxt[i]  = vld_q[i-1];
        ctrl_nxt[i] = ctrl_q[i-1];
      end
    end
  end

  // hazard is already low under flush
  always_comb begin
    bubble_cnt_nxt = bubble_cnt;
    if (hazard && !bus.stall && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt_nxt = bubble_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      ctrl_q     <= '{default: '0};
      bubble_cnt <= '0;
    end else begin
      vld_q      <= vld_nxt;
      ctrl_q     <= ctrl_nxt;
      bubble_cnt <= bubble_cnt_nxt;
    end
  end

  // Outputs
  assign bus.decode_ready = bus.flush || (!bus.stall && !hazard);
  assign bus.hazard       = hazard;
  assign bus.illegal_op   = bus.in_valid && dec_illegal;
  assign bus.stage_valid  = vld_q;
  assign bus.bubble_count = bubble_cnt;

  always_comb begin
    bus.stage_ctrl = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      bus.stage_ctrl[22*i +: 22] = ctrl_q[i];
    end
  end

  // instr[4:3] carry no decoded meaning for the supported opcodes
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[4:3];

endmodule
